fc_argmax_stage: RTL

- Downstream consumer of the fully-connected layer's output stream.
- Accepts M signed T-bit activations, one per valid/ready transfer.
- Tracks the running maximum and its position in the vector, then presents the winning index and value as a single result transfer.
- Sits directly after the FC layer in the classifier chain and turns M neuron outputs into one class decision.

---
 rtl/fc_pkg.sv | 18 +
 rtl/fc_argmax_stage_if.sv | 26 ++
 rtl/fc_argmax_count.sv | 28 ++
 rtl/fc_argmax_stage.sv | 69 ++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the FC-layer argmax stage.
package fc_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } state_t;

  // Index width never collapses to zero, so M=1 still gets a 1-bit index.
  function automatic int idx_width(input int m);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  function automatic logic signed [63:0] min_signed(input int t);
    return -(64'sd1 <<< (t - 1));
  endfunction

endpackage

// File: rtl/fc_argmax_stage_if.sv
// Input stream and result handshake for the argmax stage.
interface fc_argmax_stage_if #(
  parameter int M = 6,
  parameter int T = 16
);
  localparam int IW = fc_pkg::idx_width(M);

  logic                input_valid;
  logic                input_ready;
  logic signed [T-1:0] input_data;
  logic                output_valid;
  logic                output_ready;
  logic [IW-1:0]       output_index;
  logic signed [T-1:0] output_data;

  modport master (
    output input_valid, input_data, output_ready,
    input  input_ready, output_valid, output_index, output_data
  );

  modport slave (
    input  input_valid, input_data, output_ready,
    output input_ready, output_valid, output_index, output_data
  );

endinterface

// File: rtl/fc_argmax_count.sv
// Modulo-M element counter with a terminal flag on the last element.
module fc_argmax_count
  import fc_pkg::*;
#(
  parameter int M = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      incr,
  input  logic                      clr,
  output logic [idx_width(M)-1:0]   cnt,
  output logic                      last
);
  localparam int IW = idx_width(M);

  assign last = (cnt == IW'(M - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (incr) begin
      cnt <= last ? '0 : cnt + IW'(1);
    end
  end

endmodule

// File: rtl/fc_argmax_stage.sv
// Reduces an M-element FC output vector to the index and value of its maximum.
//   state   | meaning
//   COLLECT | accepting elements, tracking running max and its position
//   RESULT  | presenting index/value until downstream consumes it
module fc_argmax_stage
  import fc_pkg::*;
#(
  parameter int M = 6,
  parameter int T = 16
) (
  input logic               clk,
  input logic               reset,
  fc_argmax_stage_if.slave  bus
);
  localparam int IW = idx_width(M);
  localparam logic signed [T-1:0] MIN_VAL = T'(min_signed(T));

  state_t              state_q, state_d;
  logic                accept, consume;
  logic                cnt_last;
  logic [IW-1:0]       cnt;
  logic signed [T-1:0] max_q;
  logic [IW-1:0]       idx_q;

  assign bus.input_ready  = (state_q == COLLECT) && !reset;
  assign bus.output_valid = (state_q == RESULT);
  assign bus.output_index = idx_q;
  assign bus.output_data  = max_q;

  assign accept  = bus.input_valid && bus.input_ready;
  assign consume = bus.output_valid && bus.output_ready;

  fc_argmax_count #(.M(M)) u_count (
    .clk   (clk),
    .reset (reset),
    .incr  (accept),
    .clr   (state_q == RESULT),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && cnt_last) state_d = RESULT;
      RESULT:  if (consume)            state_d = COLLECT;
      default:                         state_d = COLLECT;
    endcase
  end

  // First element always seeds the max; strict compare keeps the earlier index on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q <= MIN_VAL;
      idx_q <= '0;
    end else if (accept) begin
      if (cnt == '0 || bus.input_data > max_q) begin
        max_q <= bus.input_data;
        idx_q <= cnt;
      end
    end
  end

endmodule
